// File: rtl/gpr_serial_file_pkg.sv
// Shared types for the bit-serial register file: operation modes and sequencer states.
package gpr_serial_pkg;

  typedef enum logic [1:0] {
    MODE_ROT = 2'd0,
    MODE_WR  = 2'd1,
    MODE_CPY = 2'd2,
    MODE_CLR = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/gpr_shift_cell.sv
// One WIDTH-bit register that shifts right (LSB out, serial bit into MSB)
// or takes a parallel load. Load wins over shift, although the top level
// never asks for both in the same cycle.
module gpr_shift_cell #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             shift_en,
  input  logic             serial_in,
  input  logic             load_en,
  input  logic [WIDTH-1:0] load_data,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_reg;

  // Register contents: clear, parallel load or one-bit right shift
  always_ff @(posedge clk) begin
    if (srst) begin
      q_reg <= '0;
    end else if (load_en) begin
      q_reg <= load_data;
    end else if (shift_en) begin
      q_reg <= {serial_in, q_reg[WIDTH-1:1]};
    end
  end

  assign q = q_reg;

endmodule

// File: rtl/gpr_serial_file.sv
// Bit-serial register file: NREG shift cells, a start/shift/done sequencer
// with an internal bit counter, and the source/destination muxing that
// implements rotate, write, copy and clear.
module gpr_serial_file
  import gpr_serial_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int NREG  = 4,
  localparam int AW    = $clog2(NREG),
  localparam int CW    = $clog2(WIDTH)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [1:0]       i_mode,
  input  logic [AW-1:0]    i_rs_addr,
  input  logic [AW-1:0]    i_rd_addr,
  input  logic             i_data_in,
  output logic             o_data_out,
  output logic             o_ready,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_first,
  output logic             o_last,
  output logic [CW-1:0]    o_bit_idx,
  input  logic             i_load,
  input  logic [AW-1:0]    i_load_addr,
  input  logic [WIDTH-1:0] i_load_data,
  input  logic [AW-1:0]    i_peek_addr,
  output logic [WIDTH-1:0] o_peek_data
);

  state_e        state_reg;
  mode_e         mode_reg;
  logic [AW-1:0] rs_reg;
  logic [AW-1:0] rd_reg;
  logic [CW-1:0] cnt_reg;
  logic          ready_reg;
  logic          busy_reg;
  logic          done_reg;

  logic [WIDTH-1:0] cell_q [NREG];
  logic [NREG-1:0]  rs_hit;
  logic [NREG-1:0]  rd_hit;
  logic [NREG-1:0]  bit0;
  logic [NREG-1:0]  shift_en;
  logic [NREG-1:0]  serial_in;
  logic [NREG-1:0]  load_en;

  logic src_rot;   // source register rotates (ROT, CPY)
  logic dst_wr;    // destination register is rewritten (WR, CPY, CLR)
  logic rs_bit;    // LSB of source, 0 if the address is out of range
  logic rd_bit;    // LSB of destination, 0 if the address is out of range
  logic fill_bit;  // bit shifted into the destination MSB
  logic in_shift;
  logic in_idle;

  assign in_shift = (state_reg == ST_SHIFT);
  assign in_idle  = (state_reg == ST_IDLE);
  assign src_rot  = (mode_reg == MODE_ROT) || (mode_reg == MODE_CPY);
  assign dst_wr   = (mode_reg != MODE_ROT);

  // Address decode compares against every legal index, so an address
  // beyond NREG selects nothing: writes vanish and reads return 0.
  genvar gi;
  generate
    for (gi = 0; gi < NREG; gi++) begin : g_cell
      assign rs_hit[gi]    = (rs_reg == AW'(gi));
      assign rd_hit[gi]    = (rd_reg == AW'(gi));
      assign bit0[gi]      = cell_q[gi][0];
      assign load_en[gi]   = in_idle && i_load && (i_load_addr == AW'(gi));
      assign shift_en[gi]  = in_shift && ((src_rot && rs_hit[gi]) || (dst_wr && rd_hit[gi]));
      // A destination takes the fill bit; a source-only register rotates.
      // For CPY with rs==rd the fill bit is rs[0], which is a rotate.
      assign serial_in[gi] = (dst_wr && rd_hit[gi]) ? fill_bit : rs_bit;

      gpr_shift_cell #(
        .WIDTH(WIDTH)
      ) u_cell (
        .clk       (i_clk),
        .srst      (i_rst),
        .shift_en  (shift_en[gi]),
        .serial_in (serial_in[gi]),
        .load_en   (load_en[gi]),
        .load_data (i_load_data),
        .q         (cell_q[gi])
      );
    end
  endgenerate

  assign rs_bit = |(rs_hit & bit0);
  assign rd_bit = |(rd_hit & bit0);

  // Select the bit entering the destination MSB for the latched mode
  always_comb begin
    fill_bit = 1'b0;
    case (mode_reg)
      MODE_WR:  fill_bit = i_data_in;
      MODE_CPY: fill_bit = rs_bit;
      default:  fill_bit = 1'b0;
    endcase
  end

  // Parallel read port, zero for an out-of-range address
  always_comb begin
    o_peek_data = '0;
    for (int k = 0; k < NREG; k++) begin
      if (i_peek_addr == AW'(k)) begin
        o_peek_data = cell_q[k];
      end
    end
  end

  // Sequencer: latch the operation, count WIDTH shift cycles, pulse done
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg <= ST_IDLE;
      mode_reg  <= MODE_ROT;
      rs_reg    <= '0;
      rd_reg    <= '0;
      cnt_reg   <= '0;
      ready_reg <= 1'b1;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (i_start) begin
            state_reg <= ST_SHIFT;
            mode_reg  <= mode_e'(i_mode);
            rs_reg    <= i_rs_addr;
            rd_reg    <= i_rd_addr;
            cnt_reg   <= '0;
            ready_reg <= 1'b0;
            busy_reg  <= 1'b1;
          end
        end
        ST_SHIFT: begin
          if (cnt_reg == CW'(WIDTH - 1)) begin
            state_reg <= ST_DONE;
            cnt_reg   <= '0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
          end else begin
            cnt_reg <= cnt_reg + CW'(1);
          end
        end
        ST_DONE: begin
          state_reg <= ST_IDLE;
          done_reg  <= 1'b0;
          ready_reg <= 1'b1;
        end
        default: begin
          state_reg <= ST_IDLE;
          cnt_reg   <= '0;
          ready_reg <= 1'b1;
          busy_reg  <= 1'b0;
          done_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign o_ready    = ready_reg;
  assign o_busy     = busy_reg;
  assign o_done     = done_reg;
  assign o_bit_idx  = cnt_reg;
  assign o_first    = busy_reg && (cnt_reg == '0);
  assign o_last     = busy_reg && (cnt_reg == CW'(WIDTH - 1));
  assign o_data_out = busy_reg ? (src_rot ? rs_bit : rd_bit) : 1'b0;

endmodule
